mul_arbiter: RTL and testbench
==============================

# mul_arbiter

Shares one sequential multiplier (one-cycle `valid_in` start pulse, `valid_out` on completion, 64-bit result `r`) between `N_REQ` requesters.
- Arbitration is round-robin; exactly one operation is in flight at a time.
- Each result is returned on a common response channel, tagged with the requester ID.
- Sits between the client blocks and the multiplier instance, and is the only driver of the multiplier's `valid_in`/`a`/`b`.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `ID_W`, `$clog2(N_REQ)`: requester ID width.
- `TIMEOUT`, 16: WAIT-cycle limit; used only with `MUL_ARB_TIMEOUT_EN`.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in `N_REQ`: request pending, one bit per requester.
- `req_a` in `N_REQ`×32: multiplier operand, per requester.
- `req_b` in `N_REQ`×32: multiplicand operand, per requester.
- `req_ready` out `N_REQ`: one-hot accept strobe.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: consumer accepts the response.
- `resp_id` out `ID_W`: ID of the requester that owns the response.
- `resp_r` out 64: product.
- `resp_err` out 1: timeout flag; tied 0 without `MUL_ARB_TIMEOUT_EN`.
- `busy` out 1: state is not IDLE.
- `mul_valid_in` out 1: start pulse to the multiplier.
- `mul_a` out 32: operand to the multiplier.
- `mul_b` out 32: operand to the multiplier.
- `mul_valid_out` in 1: completion from the multiplier.
- `mul_r` in 64: result from the multiplier.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any `req_valid` is set, the round-robin arbiter picks winner g, searching from `last+1` upward and wrapping.
  - `req_ready[g]=1` combinationally in the same cycle.
  - At the clock edge: latch `a`, `b` and `id=g`, set `last=g`, go to ISSUE.
  - Requesters must hold `req_valid`, `req_a` and `req_b` stable until `req_ready` is seen.
- **ISSUE:**
  - `mul_valid_in=1` for exactly one cycle, with `mul_a`/`mul_b` driven from the latched operands.
  - Go to WAIT.
- **WAIT:**
  - `mul_valid_out` is ignored in the first WAIT cycle.
  - From the second WAIT cycle on, the first `mul_valid_out=1` captures `mul_r` into the response register and moves to RESP.
- **RESP:**
  - `resp_valid=1`, with `resp_id`/`resp_r`/`resp_err` stable.
  - Hold until `resp_ready=1`, then go to IDLE.
- **Stale completions:** the multiplier keeps `valid_out` high after it finishes. `mul_valid_out` is therefore ignored in IDLE, ISSUE and RESP.
- **Operand registers:** `mul_a`/`mul_b` hold the latched operands in every state. `mul_valid_in` is 0 outside ISSUE.
- **Requests during activity:** a requester that asserts `req_valid` while `busy` waits; no request is dropped.
- **Re-request from the last winner:** it waits behind every other pending requester (round-robin fairness).
- **Reset:**
  - Outputs: `req_ready=0`, `resp_valid=0`, `resp_id=0`, `resp_r=0`, `resp_err=0`, `busy=0`, `mul_valid_in=0`, `mul_a=0`, `mul_b=0`.
  - State: IDLE, `last=N_REQ-1` (requester 0 wins first).
  - Reset mid-operation abandons the in-flight product; the next issue restarts the multiplier via `mul_valid_in`.

## Timing
- Cycle 0 (IDLE): accept. Cycle 1: ISSUE. Cycle 2 onward: WAIT.
- The multiplier completes 2..9 cycles after ISSUE (early exit when the remaining multiplier nibbles are 0).
- `resp_valid` rises the cycle after `mul_valid_out` is captured.
- Best case: accept to `resp_valid` in 4 cycles. Worst case (no timeout): 11 cycles.
- Back-to-back throughput: one operation per (latency + 1) cycles, because RESP→IDLE costs one cycle.
- `resp_ready` held high: RESP lasts exactly one cycle.

## Configuration
- **`MUL_ARB_TIMEOUT_EN` defined:**
  - A 5-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT` without a completion: go to RESP with `resp_r=0`, `resp_err=1`.
  - A late `mul_valid_out` after the timeout is ignored, as a stale completion.
- **Undefined:** no counter is built, `resp_err` is constant 0, and WAIT waits indefinitely.

## Structure
- **Package `mul_arb_pkg`:** state enum `mul_arb_state_t` (IDLE, ISSUE, WAIT, RESP), `OPERAND_W=32`, `PRODUCT_W=64`, default `TIMEOUT`.
- **Sub-module `rr_arbiter`:** inputs `req[N_REQ]` and `last`; outputs `grant` (one-hot) and `grant_id`. Purely combinational; the `last` register lives in `mul_arbiter`.

## Test plan
- **Single request:** requester 0 sends `a=3`, `b=5` → `resp_valid` with `resp_id=0`, `resp_r=15`, `resp_err=0`, exactly 4 cycles after accept.
- **Worst-case operands:** `a=0xFFFFFFFF`, `b=0xFFFFFFFF` → `resp_r=0xFFFFFFFE00000001`, 11 cycles after accept. Then `a=0`, `b=7` → `resp_r=0` at minimum latency.
- **Round-robin fairness:** all 4 requesters held valid with distinct operands → grants in order 0,1,2,3,0; every `resp_id` matches its product.
- **Backpressure:** `resp_ready=0` for 5 cycles → `resp_valid`, `resp_id` and `resp_r` stay stable, no new `req_ready` is issued, and the stale high `mul_valid_out` is ignored.
- **Reset mid-WAIT:** `reset` pulsed during WAIT → all outputs return to their reset values. The next request from requester 2 alone completes correctly, with requester 0 priority restored.
- **Timeout (`MUL_ARB_TIMEOUT_EN`):** stub multiplier that never asserts `valid_out` → after 16 WAIT cycles, `resp_err=1`, `resp_r=0`, then back to IDLE.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the multiplier arbiter.
package mul_arb_pkg;

    localparam int unsigned OPERAND_W       = 32;
    localparam int unsigned PRODUCT_W       = 64;
    localparam int unsigned DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } mul_arb_state_t;

endpackage

// File: rtl/mul_arbiter_rr_arbiter.sv
// Combinational round-robin pick: search from last+1 upward, wrapping.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id
);

    logic        found;
    int unsigned idx;

    // First requester after the previous winner takes the grant.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = (32'(last) + i) % N_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one sequential multiplier between N_REQ requesters, one operation
// in flight, results returned on a common channel tagged with requester ID.
// Optional feature: define MUL_ARB_TIMEOUT_EN to bound the WAIT state to
// TIMEOUT cycles and flag expired operations with resp_err.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ID_W    = $clog2(N_REQ),
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [N_REQ-1:0]                    req_valid,
    input  logic [N_REQ-1:0][OPERAND_W-1:0]     req_a,
    input  logic [N_REQ-1:0][OPERAND_W-1:0]     req_b,
    output logic [N_REQ-1:0]                    req_ready,
    output logic                                resp_valid,
    input  logic                                resp_ready,
    output logic [ID_W-1:0]                     resp_id,
    output logic [PRODUCT_W-1:0]                resp_r,
    output logic                                resp_err,
    output logic                                busy,
    output logic                                mul_valid_in,
    output logic [OPERAND_W-1:0]                mul_a,
    output logic [OPERAND_W-1:0]                mul_b,
    input  logic                                mul_valid_out,
    input  logic [PRODUCT_W-1:0]                mul_r
);

    // Elaboration-time parameter sanity; the timeout counter is 5 bits wide.
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("mul_arbiter: N_REQ must be within 2..8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 31) begin : g_bad_timeout
        $error("mul_arbiter: TIMEOUT must be within 1..31");
    end

    mul_arb_state_t   state;
    logic [ID_W-1:0]  last;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    // The multiplier's valid_out may still be high from the previous run here.
    logic             first_wait;

`ifdef MUL_ARB_TIMEOUT_EN
    logic [4:0]       tmo_cnt;
`else
    assign resp_err = 1'b0;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req      (req_valid),
        .last     (last),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready    = (state == IDLE && !reset) ? grant : '0;
    assign mul_valid_in = (state == ISSUE);
    assign resp_valid   = (state == RESP);
    assign busy         = (state != IDLE);

    // Control FSM plus operand and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last       <= ID_W'(N_REQ - 1);
            mul_a      <= '0;
            mul_b      <= '0;
            resp_id    <= '0;
            resp_r     <= '0;
            first_wait <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
            resp_err   <= 1'b0;
            tmo_cnt    <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req_valid) begin
                        mul_a   <= req_a[grant_id];
                        mul_b   <= req_b[grant_id];
                        resp_id <= grant_id;
                        last    <= grant_id;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    first_wait <= 1'b1;
`ifdef MUL_ARB_TIMEOUT_EN
                    tmo_cnt    <= '0;
`endif
                    state      <= WAIT;
                end
                WAIT: begin
                    first_wait <= 1'b0;
                    if (!first_wait && mul_valid_out) begin
                        resp_r   <= mul_r;
`ifdef MUL_ARB_TIMEOUT_EN
                        resp_err <= 1'b0;
`endif
                        state    <= RESP;
                    end
`ifdef MUL_ARB_TIMEOUT_EN
                    else if (tmo_cnt == 5'(TIMEOUT - 1)) begin
                        resp_r   <= '0;
                        resp_err <= 1'b1;
                        state    <= RESP;
                    end else begin
                        tmo_cnt  <= tmo_cnt + 5'd1;
                    end
`endif
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed self-checking bench for mul_arbiter with a behavioural
// nibble-serial multiplier (2..9 cycles, valid_out held high when done).
module tb_mul_arbiter;

    localparam int N = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       req_valid;
    logic [N-1:0][31:0] req_a;
    logic [N-1:0][31:0] req_b;
    logic [N-1:0]       req_ready;
    logic               resp_valid;
    logic               resp_ready;
    logic [1:0]         resp_id;
    logic [63:0]        resp_r;
    logic               resp_err;
    logic               busy;
    logic               mul_valid_in;
    logic [31:0]        mul_a;
    logic [31:0]        mul_b;
    logic               mul_valid_out;
    logic [63:0]        mul_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_arbiter #(
        .N_REQ   (N),
        .ID_W    (2),
        .TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_r        (resp_r),
        .resp_err      (resp_err),
        .busy          (busy),
        .mul_valid_in  (mul_valid_in),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_valid_out (mul_valid_out),
        .mul_r         (mul_r)
    );

    // Multiplier model: done 1+nibbles cycles after the start edge; valid_out
    // is only cleared one edge after the restart, so it is stale in WAIT #1.
    logic        stub_dead = 1'b0;
    logic        m_run     = 1'b0;
    logic        m_vout    = 1'b0;
    int          m_cnt     = 0;
    logic [63:0] m_prod    = '0;
    logic [63:0] m_r       = '0;

    function automatic int nib_count(input logic [31:0] a);
        int n = 1;
        for (int i = 0; i < 8; i++) begin
            if (a[4*i +: 4] != 4'h0) n = i + 1;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (mul_valid_in) begin
            m_cnt  <= nib_count(mul_a);
            m_run  <= 1'b1;
            m_prod <= {32'b0, mul_a} * {32'b0, mul_b};
        end else if (m_run) begin
            if (m_cnt == 1) begin
                m_vout <= 1'b1;
                m_r    <= m_prod;
                m_run  <= 1'b0;
            end else begin
                m_cnt  <= m_cnt - 1;
                m_vout <= 1'b0;
            end
        end
    end

    assign mul_valid_out = m_vout && !stub_dead;
    assign mul_r         = m_r;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " req_ready"}, 64'(req_ready), 64'(0));
        check_eq({tag, " resp_valid"}, 64'(resp_valid), 64'(0));
        check_eq({tag, " resp_id"}, 64'(resp_id), 64'(0));
        check_eq({tag, " resp_r"}, resp_r, 64'(0));
        check_eq({tag, " resp_err"}, 64'(resp_err), 64'(0));
        check_eq({tag, " busy"}, 64'(busy), 64'(0));
        check_eq({tag, " mul_valid_in"}, 64'(mul_valid_in), 64'(0));
        check_eq({tag, " mul_a"}, 64'(mul_a), 64'(0));
        check_eq({tag, " mul_b"}, 64'(mul_b), 64'(0));
    endtask

    // Present a lone request at a negedge, expect it granted, drop after accept.
    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
        @(negedge clk);
        req_a[id]     = a;
        req_b[id]     = b;
        req_valid[id] = 1'b1;
        #1;
        check_eq({tag, " grant"}, 64'(req_ready), 64'(1) << id);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    // Cycles from accept edge to resp_valid (cycle 1 = ISSUE), bounded.
    task automatic wait_resp(input string tag, input int exp_lat);
        int n = 0;
        int pulses = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
            if (mul_valid_in) pulses++;
        end while (!resp_valid && n < 40);
        check_eq({tag, " latency"}, 64'(n), 64'(exp_lat));
        check_eq({tag, " issue pulses"}, 64'(pulses), 64'(1));
    endtask

    // Check the response, then (resp_ready high) expect RESP to last one cycle.
    task automatic check_resp(input string tag, input int id, input logic [63:0] r,
                              input logic err);
        check_eq({tag, " resp_valid"}, 64'(resp_valid), 64'(1));
        check_eq({tag, " resp_id"}, 64'(resp_id), 64'(id));
        check_eq({tag, " resp_r"}, resp_r, r);
        check_eq({tag, " resp_err"}, 64'(resp_err), 64'(err));
        @(negedge clk);
        #1;
        check_eq({tag, " back to idle"}, 64'({resp_valid, busy}), 64'(0));
    endtask

    int          rr_id [5] = '{0, 1, 2, 3, 0};
    logic [63:0] rr_r  [5] = '{64'd200, 64'd303, 64'd408, 64'd515, 64'd99};

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Single request, best-case latency.
        issue(0, 32'd3, 32'd5, "single");
        wait_resp("single", 4);
        check_resp("single", 0, 64'd15, 1'b0);

        // Worst case, then minimum latency with a stale valid_out still high.
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "worst");
        wait_resp("worst", 11);
        check_resp("worst", 0, 64'hFFFF_FFFE_0000_0001, 1'b0);
        issue(0, 32'd0, 32'd7, "zero");
        wait_resp("zero", 4);
        check_resp("zero", 0, 64'd0, 1'b0);

        // Round robin after reset: requester 0 first, re-request waits its turn.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < N; k++) begin
            req_a[k] = 32'(k + 2);
            req_b[k] = 32'(100 + k);
        end
        req_valid = '1;
        #1;
        for (int i = 0; i < 5; i++) begin
            int n = 0;
            while (req_ready == '0 && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            check_eq("rr grant", 64'(req_ready), 64'(1) << rr_id[i]);
            @(posedge clk);
            #1;
            if (i == 0) begin
                req_a[0] = 32'd9;
                req_b[0] = 32'd11;
            end else begin
                req_valid[rr_id[i]] = 1'b0;
            end
            wait_resp("rr", 4);
            check_resp("rr", rr_id[i], rr_r[i], 1'b0);
        end

        // Backpressure with another request pending behind it.
        resp_ready = 1'b0;
        issue(1, 32'h1234_5678, 32'h10, "bp");
        req_a[2]     = 32'd5;
        req_b[2]     = 32'd6;
        req_valid[2] = 1'b1;
        wait_resp("bp", 11);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check_eq("bp hold valid", 64'(resp_valid), 64'(1));
            check_eq("bp hold id", 64'(resp_id), 64'(1));
            check_eq("bp hold r", resp_r, 64'h1_2345_6780);
            check_eq("bp no grant", 64'(req_ready), 64'(0));
        end
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        check_eq("bp next grant", 64'(req_ready), 64'(4));
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        wait_resp("bp2", 4);
        check_resp("bp2", 2, 64'd30, 1'b0);

        // Reset in the middle of WAIT, then a clean run from requester 2.
        issue(1, 32'hFFFF_FFFF, 32'd2, "rst");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst mid");
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        issue(2, 32'd7, 32'd8, "rst2");
        wait_resp("rst2", 4);
        check_resp("rst2", 2, 64'd56, 1'b0);

`ifdef MUL_ARB_TIMEOUT_EN
        // Dead multiplier: 16 WAIT cycles then an error response.
        stub_dead = 1'b1;
        issue(0, 32'd1, 32'd1, "tmo");
        wait_resp("tmo", 18);
        check_resp("tmo", 0, 64'd0, 1'b1);
        stub_dead = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
